// File: rtl/filt_sequencer.sv
// Filter sequencer: buffers ADC samples in a small FIFO and walks each one
// through an external filter datapath (load, start pulse, wait for done, capture).
module filt_sequencer #(
    parameter int unsigned XADC_DATA_SIZE = 16,
    parameter int unsigned FIFO_AW        = 3,
    parameter int unsigned START_LEN      = 2,
    parameter int unsigned TIMEOUT        = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic [1:0]                sel_req_i,
    input  logic                      smp_valid_i,
    input  logic [XADC_DATA_SIZE-1:0] smp_data_i,
    output logic                      filt_start_o,
    output logic [1:0]                filt_select_o,
    output logic [XADC_DATA_SIZE-1:0] filt_sample_o,
    input  logic [XADC_DATA_SIZE-1:0] filt_result_i,
    input  logic                      filt_done_i,
    output logic                      out_valid_o,
    output logic [XADC_DATA_SIZE-1:0] out_data_o,
    output logic [1:0]                out_sel_o,
    output logic                      busy_o,
    output logic [FIFO_AW:0]          fifo_level_o,
    output logic                      ovf_o,
    output logic                      timeout_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StCapture} state_e;

    state_e                    state_q;
    logic [XADC_DATA_SIZE-1:0] mem_q [Depth];
    logic [FIFO_AW-1:0]        wptr_q, rptr_q;
    logic [FIFO_AW:0]          count_q;
    logic                      full, empty, push, pop, drop;
    logic                      ovf_q, timeout_q, done_q;
    logic [15:0]               drop_cnt_q;
    logic [3:0]                start_cnt_q;
    logic [9:0]                wait_cnt_q;
    logic                      filt_start_q, out_valid_q;
    logic [1:0]                filt_select_q, out_sel_q;
    logic [XADC_DATA_SIZE-1:0] filt_sample_q, result_q, out_data_q;

    assign full  = (count_q == (FIFO_AW + 1)'(Depth));
    assign empty = (count_q == '0);
    // The only pop happens in LOAD, which is entered only with a non-empty FIFO.
    assign pop   = (state_q == StLoad);
    assign push  = smp_valid_i && (!full || pop);
    assign drop  = smp_valid_i && full && !pop;

    // Sample storage; when full with a same-cycle pop, wptr == rptr and the read
    // below still sees the old head because both are non-blocking.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= smp_data_i;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Sticky overflow and saturating drop counter; a drop wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (clr_i)                      drop_cnt_q <= 16'd1;
            else if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end else if (clr_i) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    // Registered copy of filt_done for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= filt_done_i;
    end

    // Sequencing FSM with registered datapath-side and result-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            filt_start_q  <= 1'b0;
            filt_select_q <= '0;
            filt_sample_q <= '0;
            result_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sel_q     <= '0;
            timeout_q     <= 1'b0;
            start_cnt_q   <= '0;
            wait_cnt_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            // Later assignment in WAIT overrides this, so a same-cycle timeout wins.
            if (clr_i) timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i && !empty) state_q <= StLoad;
                end
                StLoad: begin
                    filt_sample_q <= mem_q[rptr_q];
                    if (sel_req_i != 2'b11) filt_select_q <= sel_req_i;
                    filt_start_q  <= 1'b1;
                    start_cnt_q   <= '0;
                    state_q       <= StStart;
                end
                StStart: begin
                    if (start_cnt_q == 4'(START_LEN - 1)) begin
                        filt_start_q <= 1'b0;
                        wait_cnt_q   <= '0;
                        state_q      <= StWait;
                    end else begin
                        start_cnt_q <= start_cnt_q + 4'd1;
                    end
                end
                StWait: begin
                    if (done_q && !filt_done_i) begin
                        result_q <= filt_result_i;
                        state_q  <= StCapture;
                    end else if (wait_cnt_q == 10'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 10'd1;
                    end
                end
                StCapture: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= result_q;
                    out_sel_q   <= filt_select_q;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign filt_start_o  = filt_start_q;
    assign filt_select_o = filt_select_q;
    assign filt_sample_o = filt_sample_q;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_sel_o     = out_sel_q;
    assign busy_o        = (state_q != StIdle);
    assign fifo_level_o  = count_q;
    assign ovf_o         = ovf_q;
    assign timeout_o     = timeout_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_filt_sequencer.sv
// Directed bench for filt_sequencer with a behavioural filter model.
module tb_filt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, clr = 1'b0, smp_valid = 1'b0;
    logic [1:0]  sel_req = 2'b00;
    logic [15:0] smp_data = '0;
    logic        filt_start, filt_done = 1'b0;
    logic [1:0]  filt_select, out_sel;
    logic [15:0] filt_sample, filt_result = '0, out_data, drop_cnt;
    logic        out_valid, busy, ovf, timeout;
    logic [3:0]  fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Filter model controls and bookkeeping.
    int   dly = 20;
    logic hang = 1'b0;
    int   mdl_cnt = 0;
    logic mdl_active = 1'b0;
    logic start_prev = 1'b0;
    int   start_cyc = 0;
    int   fall_cyc = 0;

    // Output monitor.
    logic [15:0] od[$];
    logic [1:0]  os[$];
    int          out_cnt = 0;
    int          lat_last = 0;

    filt_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en),
        .clr_i         (clr),
        .sel_req_i     (sel_req),
        .smp_valid_i   (smp_valid),
        .smp_data_i    (smp_data),
        .filt_start_o  (filt_start),
        .filt_select_o (filt_select),
        .filt_sample_o (filt_sample),
        .filt_result_i (filt_result),
        .filt_done_i   (filt_done),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .out_sel_o     (out_sel),
        .busy_o        (busy),
        .fifo_level_o  (fifo_level),
        .ovf_o         (ovf),
        .timeout_o     (timeout),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Filter model: raise done at start, drop it dly cycles later (never when hang).
    initial forever begin
        @(negedge clk);
        if (filt_start && !start_prev) begin
            filt_done   = 1'b1;
            filt_result = filt_sample + 16'd1;
            mdl_cnt     = 0;
            mdl_active  = 1'b1;
            start_cyc   = cyc;
        end else if (mdl_active && !hang) begin
            mdl_cnt++;
            if (mdl_cnt >= dly) begin
                filt_done  = 1'b0;
                mdl_active = 1'b0;
                fall_cyc   = cyc;
            end
        end
        start_prev = filt_start;
    end

    initial forever begin
        @(negedge clk);
        if (out_valid) begin
            od.push_back(out_data);
            os.push_back(out_sel);
            lat_last = cyc - fall_cyc;
            out_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("check %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        smp_valid = 1'b1;
        smp_data  = d;
        @(negedge clk);
        smp_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k = 0;
        while (out_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, out_cnt, n);
    endtask

    initial begin
        int base;
        int k;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start", filt_start, 0);
        check("rst_valid", out_valid, 0);
        check("rst_flags", {ovf, timeout}, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_data", {filt_select, out_sel, filt_sample, out_data}, 0);
        rst = 1'b0;

        // Three BPF samples with slow filter; latency and order.
        base = out_cnt;
        dly = 215;
        en = 1'b1;
        sel_req = 2'b10;
        @(negedge clk);
        smp_valid = 1'b1;
        smp_data  = 16'd100;
        @(negedge clk);
        smp_valid = 1'b0;
        check("lat_level1", fifo_level, 1);
        check("lat_idle", busy, 0);
        @(negedge clk);
        check("lat_load_busy", busy, 1);
        check("lat_load_nostart", filt_start, 0);
        @(negedge clk);
        check("lat_start", filt_start, 1);
        check("lat_sample", filt_sample, 100);
        check("lat_select", filt_select, 2);
        check("lat_level0", fifo_level, 0);
        push(16'd200);
        push(16'd300);
        wait_out(base + 3, 1000, "bpf_count");
        check("bpf_d0", od[base], 101);
        check("bpf_d1", od[base + 1], 201);
        check("bpf_d2", od[base + 2], 301);
        check("bpf_sel", os[base + 2], 2);
        check("valid_latency", lat_last, 2);

        // sel_req changes only take effect at LOAD; 11 keeps previous select.
        base = out_cnt;
        dly = 20;
        sel_req = 2'b00;
        push(16'd5);
        repeat (8) @(negedge clk);
        check("sel_in_wait", busy, 1);
        sel_req = 2'b01;
        push(16'd7);
        check("sel_held", filt_select, 0);
        wait_out(base + 2, 200, "sel_count");
        check("sel_first", os[base], 0);
        check("sel_second", os[base + 1], 1);
        check("sel_data", od[base + 1], 8);
        sel_req = 2'b11;
        push(16'd9);
        wait_out(base + 3, 200, "sel11_count");
        check("sel11_out", os[base + 2], 1);
        check("sel11_reg", filt_select, 1);
        check("sel11_data", od[base + 2], 10);

        // Overflow with en low, clear priority, then drain.
        base = out_cnt;
        en = 1'b0;
        sel_req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            smp_valid = 1'b1;
            smp_data  = 16'(10 + i);
        end
        @(negedge clk);
        smp_valid = 1'b0;
        check("ovf_level", fifo_level, 8);
        check("ovf_flag", ovf, 1);
        check("ovf_drop2", drop_cnt, 2);
        @(negedge clk);
        smp_valid = 1'b1;
        smp_data  = 16'd0;
        clr = 1'b1;
        @(negedge clk);
        smp_valid = 1'b0;
        clr = 1'b0;
        check("clr_prio_drop", drop_cnt, 1);
        check("clr_prio_ovf", ovf, 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_drop", drop_cnt, 0);
        check("clr_level", fifo_level, 8);
        en = 1'b1;
        wait_out(base + 8, 800, "drain_count");
        repeat (60) @(negedge clk);
        check("drain_exact", out_cnt, base + 8);
        check("drain_first", od[base], 11);
        check("drain_last", od[base + 7], 18);

        // Full FIFO with pop in LOAD and push in the same cycle.
        base = out_cnt;
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            smp_valid = 1'b1;
            smp_data  = 16'(30 + i);
        end
        @(negedge clk);
        smp_valid = 1'b0;
        en = 1'b1;
        @(negedge clk);
        check("fullpop_load", busy, 1);
        check("fullpop_full", fifo_level, 8);
        smp_valid = 1'b1;
        smp_data  = 16'd99;
        @(negedge clk);
        smp_valid = 1'b0;
        check("fullpop_level", fifo_level, 8);
        check("fullpop_ovf", ovf, 0);
        check("fullpop_drop", drop_cnt, 0);
        wait_out(base + 9, 800, "fullpop_count");
        check("fullpop_first", od[base], 31);
        check("fullpop_last", od[base + 8], 100);

        // Filter never drops done -> timeout, then normal recovery.
        base = out_cnt;
        hang = 1'b1;
        push(16'd50);
        k = 0;
        while (!timeout && k < 1200) begin
            @(negedge clk);
            k++;
        end
        check("to_flag", timeout, 1);
        check("to_cycles", cyc - start_cyc, 1025);
        check("to_idle", busy, 0);
        check("to_noout", out_cnt, base);
        hang = 1'b0;
        push(16'd60);
        wait_out(base + 1, 200, "to_recover");
        check("to_rec_data", od[base], 61);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("to_clr", timeout, 0);

        // Asynchronous reset during WAIT.
        base = out_cnt;
        dly = 100;
        push(16'd70);
        repeat (10) @(negedge clk);
        check("rstw_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rstw_busy0", busy, 0);
        check("rstw_outs", {filt_start, out_valid, filt_select, out_sel}, 0);
        check("rstw_data", {filt_sample, out_data}, 0);
        check("rstw_level", fifo_level, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check("rstw_noout", out_cnt, base);
        dly = 20;
        push(16'd80);
        wait_out(base + 1, 200, "rstw_recover");
        check("rstw_rec_data", od[base], 81);
        check("rstw_rec_sel", os[base], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filt_sequencer.md
FILT_SEQUENCER -- requirements
Module: filt_sequencer

Interface
REQ-001 SHALL have parameter XADC_DATA_SIZE, default 16, meaning sample/result width.
REQ-002 SHALL have parameter FIFO_AW, default 3, meaning log2 of the sample FIFO depth (depth 8).
REQ-003 SHALL have parameter START_LEN, default 2, meaning the filt_start pulse length in clk cycles (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 1023, meaning the maximum WAIT cycles before abort (10-bit counter).
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports: en in 1, run enable; clr in 1, clear sticky status.
REQ-007 SHALL have ports: sel_req in 2, requested filter (00 LPF, 01 HPF, 10 BPF, 11 invalid).
REQ-008 SHALL have ports: smp_valid in 1, sample strobe; smp_data in XADC_DATA_SIZE, ADC sample.
REQ-009 SHALL have ports: filt_start out 1; filt_select out 2; filt_sample out XADC_DATA_SIZE; filt_result in XADC_DATA_SIZE; filt_done in 1 (filter datapath side).
REQ-010 SHALL have ports: out_valid out 1; out_data out XADC_DATA_SIZE; out_sel out 2 (filtered result stream).
REQ-011 SHALL have ports: busy out 1; fifo_level out FIFO_AW+1; ovf out 1; timeout out 1; drop_cnt out 16.

Function
REQ-012 SHALL buffer samples in a 2^FIFO_AW-entry FIFO; push on smp_valid when not full, or when full with a pop in the same cycle.
REQ-013 SHALL drop a sample arriving when full without a same-cycle pop, set ovf sticky, and increment drop_cnt, saturating at 16'hFFFF.
REQ-014 SHALL report fifo_level as the registered occupancy (0..2^FIFO_AW); pointers wrap modulo depth.
REQ-015 SHALL implement FSM states IDLE, LOAD, START, WAIT, CAPTURE; busy=1 in every state except IDLE.
REQ-016 IDLE -> LOAD when en=1 and FIFO not empty; otherwise remain in IDLE.
REQ-017 LOAD (1 cycle): SHALL pop the FIFO head into filt_sample and latch sel_req into filt_select; if sel_req=11, filt_select SHALL keep its previous value; -> START.
REQ-018 START: filt_start=1 for exactly START_LEN cycles, then -> WAIT; filt_done SHALL be ignored in START.
REQ-019 WAIT: completion SHALL be a falling edge of filt_done (registered value 1 last cycle, 0 this cycle); on completion -> CAPTURE and filt_result registered.
REQ-020 WAIT: a cycle counter starting at 0 on entry; if it reaches TIMEOUT without completion, SHALL set timeout sticky, produce no output, and -> IDLE.
REQ-021 CAPTURE (1 cycle): SHALL assert out_valid for one cycle with out_data = captured result, out_sel = filt_select; -> IDLE.
REQ-022 Latency: from a pop in LOAD, filt_start SHALL rise on the next cycle; out_valid SHALL be asserted 2 cycles after the filt_done falling edge is sampled.
REQ-023 filt_sample and filt_select SHALL be held stable from LOAD until the next LOAD.
REQ-024 Deasserting en mid-operation SHALL let the current sample complete; no new LOAD occurs while en=0; the FIFO keeps accepting samples.
REQ-025 sel_req changes SHALL take effect only at LOAD, never mid-operation.
REQ-026 clr SHALL clear ovf, timeout, and drop_cnt; a same-cycle overflow or timeout event SHALL take priority (flag set, drop_cnt=1).

Reset
REQ-027 On rst=1 (asynchronous) the state SHALL be IDLE and the FIFO empty; filt_start, out_valid, busy, ovf, and timeout SHALL be 0; filt_select, out_sel, filt_sample, and out_data SHALL be 0; drop_cnt and fifo_level SHALL be 0.
REQ-028 rst asserted mid-operation SHALL abort immediately with no out_valid pulse; after release, operation SHALL resume from IDLE.

Verification
REQ-029 en=1, sel_req=10, push 3 samples (100,200,300); model filter returns sample+1 with done falling edge 215 cycles after start -> three out_valid pulses, data 101,201,301, out_sel=10, order preserved.
REQ-030 en=0, push 10 samples -> fifo_level=8, ovf=1, drop_cnt=2; then en=1 -> exactly 8 outputs; clr -> ovf=0, drop_cnt=0.
REQ-031 Model filter never drops filt_done -> timeout=1 after START_LEN+1023 cycles, no out_valid, FSM back to IDLE, next sample processed normally.
REQ-032 sel_req toggled 00->01 during WAIT -> current out_sel=00, next out_sel=01; sel_req=11 at LOAD -> filt_select unchanged.
REQ-033 rst pulsed during WAIT -> all outputs 0, fifo_level=0, no out_valid; after release a new sample completes normally.
REQ-034 FIFO full with a pop in LOAD and smp_valid in the same cycle -> sample accepted, fifo_level stays 8, ovf stays 0.
